iir_sos_tdm_sched: RTL and testbench

//  Frame-level sequencer that shares one biquad (SOS) engine across NSEC cascade sections by time-multiplexing.

---
 rtl/iir_sos_tdm_sched_pkg.sv | 20 ++
 rtl/iir_sos_tdm_sched_if.sv | 23 ++
 rtl/iir_sos_tdm_sched_next_sec.sv | 29 ++
 rtl/iir_sos_tdm_sched.sv | 231 +++++++++++++++++++++++
 tb/tb_iir_sos_tdm_sched.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_sos_tdm_sched_pkg.sv
// Shared types and default sizes for the time-multiplexed biquad cascade sequencer.
package iir_sos_tdm_sched_pkg;

    // Section index width; the cascade holds at most 8 sections
    localparam int SEC_W    = 3;
    localparam int NSEC_DEF = 7;
    localparam int DW_DEF   = 16;
    localparam int AW_DEF   = 11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_IN  = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ENG = 3'd3,
        ST_EMIT     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

endpackage

// File: rtl/iir_sos_tdm_sched_if.sv
// Bus between the sequencer (master) and the shared biquad engine (slave).
interface iir_sos_tdm_sched_if
    import iir_sos_tdm_sched_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic             eng_clr;
    logic             eng_start;
    logic [SEC_W-1:0] eng_sec;
    logic [DW-1:0]    eng_x;
    logic [DW-1:0]    eng_y;
    logic             eng_done;

    modport master (
        output eng_clr, eng_start, eng_sec, eng_x,
        input  eng_y, eng_done
    );

    modport slave (
        input  eng_clr, eng_start, eng_sec, eng_x,
        output eng_y, eng_done
    );
endinterface

// File: rtl/iir_sos_tdm_sched_next_sec.sv
// Priority finder: lowest enabled section strictly above idx_i, or the lowest
// enabled section overall when first_i is set.
module iir_sos_tdm_sched_next_sec
    import iir_sos_tdm_sched_pkg::*;
#(
    parameter int NSEC = NSEC_DEF
) (
    input  logic [NSEC-1:0]  mask_i,
    input  logic [SEC_W-1:0] idx_i,
    input  logic             first_i,
    output logic [SEC_W-1:0] nxt_o,
    output logic             found_o
);

    logic hit_s;

    // Scan from the top down so the lowest qualifying index is the last one kept
    always_comb begin
        nxt_o   = {SEC_W{1'b0}};
        found_o = 1'b0;
        hit_s   = 1'b0;
        for (int i = NSEC - 1; i >= 0; i--) begin
            hit_s   = mask_i[i] & (first_i | (i > int'(idx_i)));
            nxt_o   = hit_s ? SEC_W'(i) : nxt_o;
            found_o = found_o | hit_s;
        end
    end

endmodule

// File: rtl/iir_sos_tdm_sched.sv
// Frame sequencer that walks each input sample through the enabled biquad
// sections on one shared engine, then emits the result with its frame address.
module iir_sos_tdm_sched
    import iir_sos_tdm_sched_pkg::*;
#(
    parameter int NSEC        = NSEC_DEF,
    parameter int DW          = DW_DEF,
    parameter int AW          = AW_DEF,
    parameter int FRAME_LEN   = 2048,
    parameter int ENG_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [NSEC-1:0]     sec_en_i,
    input  logic [DW-1:0]       in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    iir_sos_tdm_sched_if.master eng,
    output logic [DW-1:0]       out_data_o,
    output logic [AW-1:0]       out_addr_o,
    output logic                out_valid_o,
    output logic                done_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int TW = $clog2(ENG_TIMEOUT + 1);

    // Sequencer state
    state_e           state_q, state_d;
    logic [NSEC-1:0]  mask_q, mask_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic [DW-1:0]    cur_q, cur_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             clr_d;

    // Registered outputs
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             eng_clr_q;
    logic             eng_start_q, eng_start_d;
    logic [SEC_W-1:0] eng_sec_q, eng_sec_d;
    logic [DW-1:0]    eng_x_q, eng_x_d;
    logic [DW-1:0]    out_data_q, out_data_d;
    logic [AW-1:0]    out_addr_q, out_addr_d;
    logic             out_valid_q, out_valid_d;
    logic             done_q, done_d;

    // Section finder: "first" mode while waiting for a new sample
    logic             first_s;
    logic [SEC_W-1:0] nxt_sec_s;
    logic             found_s;

    assign first_s = (state_q == ST_WAIT_IN);

    iir_sos_tdm_sched_next_sec #(
        .NSEC (NSEC)
    ) u_next_sec (
        .mask_i  (mask_q),
        .idx_i   (sec_q),
        .first_i (first_s),
        .nxt_o   (nxt_sec_s),
        .found_o (found_s)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= {NSEC{1'b0}};
            addr_q      <= {AW{1'b0}};
            sec_q       <= {SEC_W{1'b0}};
            cur_q       <= {DW{1'b0}};
            tmo_q       <= {TW{1'b0}};
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            eng_clr_q   <= 1'b0;
            eng_start_q <= 1'b0;
            eng_sec_q   <= {SEC_W{1'b0}};
            eng_x_q     <= {DW{1'b0}};
            out_data_q  <= {DW{1'b0}};
            out_addr_q  <= {AW{1'b0}};
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            sec_q       <= sec_d;
            cur_q       <= cur_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            eng_clr_q   <= clr_d;
            eng_start_q <= eng_start_d;
            eng_sec_q   <= eng_sec_d;
            eng_x_q     <= eng_x_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; abort overrides every transition and leaves err alone
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        sec_d   = sec_q;
        cur_d   = cur_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        clr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WAIT_IN;
                    mask_d  = sec_en_i;
                    addr_d  = {AW{1'b0}};
                    err_d   = 1'b0;
                    clr_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_IN: begin
                if (in_valid_i) begin
                    cur_d = in_data_i;
                    if (found_s) begin
                        sec_d   = nxt_sec_s;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end else begin
                    state_d = ST_WAIT_IN;
                end
            end
            ST_ISSUE: begin
                tmo_d   = {TW{1'b0}};
                state_d = ST_WAIT_ENG;
            end
            ST_WAIT_ENG: begin
                if (eng.eng_done) begin
                    cur_d = eng.eng_y;
                    if (found_s) begin
                        sec_d   = nxt_sec_s;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_EMIT;
                    end
                end else if (tmo_q == TW'(ENG_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_EMIT: begin
                if (addr_q == AW'(FRAME_LEN - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = ST_WAIT_IN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
            mask_d  = mask_q;
            addr_d  = addr_q;
            err_d   = err_q;
            clr_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode from the next state so every output comes straight off a flop
    always_comb begin
        in_ready_d  = (state_d == ST_WAIT_IN);
        busy_d      = (state_d != ST_IDLE);
        eng_start_d = (state_d == ST_ISSUE);
        out_valid_d = (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
        eng_sec_d   = eng_sec_q;
        eng_x_d     = eng_x_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        if (state_d == ST_ISSUE) begin
            eng_sec_d = sec_d;
            eng_x_d   = cur_d;
        end else begin
            eng_sec_d = eng_sec_q;
            eng_x_d   = eng_x_q;
        end
        if (state_d == ST_EMIT) begin
            out_data_d = cur_d;
            out_addr_d = addr_d;
        end else begin
            out_data_d = out_data_q;
            out_addr_d = out_addr_q;
        end
    end

    assign in_ready_o    = in_ready_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;
    assign out_data_o    = out_data_q;
    assign out_addr_o    = out_addr_q;
    assign out_valid_o   = out_valid_q;
    assign done_o        = done_q;
    assign eng.eng_clr   = eng_clr_q;
    assign eng.eng_start = eng_start_q;
    assign eng.eng_sec   = eng_sec_q;
    assign eng.eng_x     = eng_x_q;

endmodule

// File: tb/tb_iir_sos_tdm_sched.sv
// Randomised scoreboard bench for the biquad cascade sequencer. Engine model:
// eng_done three cycles after eng_start, eng_y = eng_x + 1.
module tb_iir_sos_tdm_sched;
    import iir_sos_tdm_sched_pkg::*;

    localparam int DW  = 16;
    localparam int AW  = 11;
    localparam int FL  = 4;
    localparam int FLB = 2048;
    localparam int L   = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start, start_b, abort, in_valid;
    logic [6:0]    sec_en;
    logic [DW-1:0] in_data;
    logic          hang, stray;

    logic          in_ready, out_valid, done, busy, err;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          in_ready_b, out_valid_b, done_b, busy_b, err_b;
    logic [DW-1:0] out_data_b;
    logic [AW-1:0] out_addr_b;

    iir_sos_tdm_sched_if #(.DW(DW)) eif ();
    iir_sos_tdm_sched_if #(.DW(DW)) eif_b ();

    iir_sos_tdm_sched #(.NSEC(7), .DW(DW), .AW(AW), .FRAME_LEN(FL), .ENG_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .sec_en_i(sec_en),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready), .eng(eif),
        .out_data_o(out_data), .out_addr_o(out_addr), .out_valid_o(out_valid),
        .done_o(done), .busy_o(busy), .err_o(err));

    iir_sos_tdm_sched #(.NSEC(7), .DW(DW), .AW(AW), .FRAME_LEN(FLB), .ENG_TIMEOUT(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort), .sec_en_i(sec_en),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready_b), .eng(eif_b),
        .out_data_o(out_data_b), .out_addr_o(out_addr_b), .out_valid_o(out_valid_b),
        .done_o(done_b), .busy_o(busy_b), .err_o(err_b));

    // Engine models
    logic [2:0]    pv = 3'b000, pv_b = 3'b000;
    logic [DW-1:0] d1, d2, d3, e1, e2, e3;
    always @(posedge clk) begin
        pv   <= {pv[1:0], eif.eng_start};
        d1   <= eif.eng_x + 16'd1;  d2 <= d1;  d3 <= d2;
        pv_b <= {pv_b[1:0], eif_b.eng_start};
        e1   <= eif_b.eng_x + 16'd1; e2 <= e1; e3 <= e2;
    end
    assign eif.eng_done   = (pv[2] & ~hang) | stray;
    assign eif.eng_y      = d3;
    assign eif_b.eng_done = pv_b[2];
    assign eif_b.eng_y    = e3;

    // Scoreboard
    typedef struct { logic [DW-1:0] data; logic [AW-1:0] addr; int due; } exp_t;
    exp_t sb[$], sbb[$];
    int   secq[$];
    int   n_cmp = 0, n_fail = 0;
    int   cyc = 0;
    logic [6:0] m_mask = 7'd0, m_mask_b = 7'd0;
    int   m_addr = 0, m_addr_b = 0;
    int   done_due = -1, done_due_b = -1;
    int   clr_cnt = 0, clr_exp = 0, nb_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int popc(input logic [6:0] m);
        int c = 0;
        for (int i = 0; i < 7; i++) c += int'(m[i]);
        return c;
    endfunction

    // Monitor for the short-frame instance
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (eif.eng_clr) clr_cnt++;
            if (eif.eng_start) begin
                if (secq.size() == 0) chk("eng_start_unexpected", 1, 0);
                else chk("eng_sec", eif.eng_sec, secq.pop_front());
            end
            if (out_valid) begin
                if (sb.size() == 0) chk("out_valid_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_addr", out_addr, e.addr);
                    chk("out_latency", cyc, e.due);
                    if (e.addr == AW'(FL - 1)) done_due = cyc + 1;
                end
            end
            if (done) begin
                chk("done_cycle", cyc, done_due);
                done_due = -1;
            end else if (done_due >= 0 && cyc >= done_due) begin
                chk("done_missing", 0, 1);
                done_due = -1;
            end
        end
    end

    // Monitor for the full-frame instance
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n) begin
            if (eif_b.eng_start) chk("b_eng_start_unexpected", 1, 0);
            if (out_valid_b) begin
                nb_out++;
                if (sbb.size() == 0) chk("b_out_valid_unexpected", 1, 0);
                else begin
                    e = sbb.pop_front();
                    chk("b_out_data", out_data_b, e.data);
                    chk("b_out_addr", out_addr_b, e.addr);
                    chk("b_out_latency", cyc, e.due);
                    if (e.addr == AW'(FLB - 1)) done_due_b = cyc + 1;
                end
            end
            if (done_b) begin
                chk("b_done_cycle", cyc, done_due_b);
                done_due_b = -1;
            end else if (done_due_b >= 0 && cyc >= done_due_b) begin
                chk("b_done_missing", 0, 1);
                done_due_b = -1;
            end
        end
    end

    task automatic do_start(input bit big, input logic [6:0] mask);
        @(negedge clk);
        sec_en = mask;
        if (big) start_b = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_b = 1'b0;
        if (big) begin
            m_mask_b = mask; m_addr_b = 0;
            chk("b_ready_after_start", in_ready_b, 1);
        end else begin
            m_mask = mask; m_addr = 0; clr_exp++;
            chk("eng_clr_pulse", eif.eng_clr, 1);
            chk("ready_after_start", in_ready, 1);
            chk("err_cleared", err, 0);
        end
        sec_en = 7'($urandom);
    endtask

    task automatic send(input bit big, input logic [DW-1:0] d, input bit expect_out, output int hs);
        int n;
        logic [6:0] mk;
        int ne;
        exp_t e;
        @(negedge clk);
        in_data = d; in_valid = 1'b1; n = 0;
        while (!(big ? in_ready_b : in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        hs = cyc;
        if (n >= 200) begin
            chk("in_ready_wait", 0, 1);
            in_valid = 1'b0;
        end else begin
            mk = big ? m_mask_b : m_mask;
            ne = popc(mk);
            if (!big) for (int i = 0; i < 7; i++) if (mk[i]) secq.push_back(i);
            if (expect_out) begin
                e.data = d + DW'(ne);
                e.addr = AW'(big ? m_addr_b : m_addr);
                e.due  = cyc + 1 + ne * (L + 1);
                if (big) begin sbb.push_back(e); m_addr_b++; end
                else begin sb.push_back(e); m_addr++; end
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit big);
        int n = 0;
        while ((big ? busy_b : busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", (n < 1000), 1);
        repeat (2) @(negedge clk);
        chk("sb_drained", big ? sbb.size() : sb.size(), 0);
    endtask

    task automatic frame(input logic [6:0] mask);
        int hs;
        do_start(0, mask);
        for (int i = 0; i < FL; i++) begin
            send(0, DW'($urandom), 1, hs);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle(0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hs;
        int n;
        rst_n = 1'b0; start = 1'b0; start_b = 1'b0; abort = 1'b0; in_valid = 1'b0;
        sec_en = 7'd0; in_data = 16'd0; hang = 1'b0; stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {in_ready, out_valid, done, busy, err, eif.eng_clr, eif.eng_start}, 0);
        chk("rst_data", {out_data, out_addr, eif.eng_sec, eif.eng_x}, 0);
        rst_n = 1'b1;

        // in_valid while IDLE is never accepted
        @(negedge clk);
        in_data = 16'h1234; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_no_ready", {in_ready, busy}, 0);
        end
        in_valid = 1'b0;

        // All seven sections, constant input
        do_start(0, 7'h7F);
        for (int i = 0; i < FL; i++) send(0, 16'h0010, 1, hs);
        wait_idle(0);

        // Sparse mask, then passthrough
        do_start(0, 7'b0000101);
        send(0, 16'h0100, 1, hs);
        for (int i = 1; i < FL; i++) send(0, DW'($urandom), 1, hs);
        wait_idle(0);
        do_start(0, 7'h00);
        send(0, 16'h8000, 1, hs);
        for (int i = 1; i < FL; i++) send(0, DW'($urandom), 1, hs);
        wait_idle(0);

        // Random masks and data
        repeat (4) frame(7'($urandom));

        // start while busy ignored; stray eng_done in WAIT_IN ignored
        do_start(0, 7'h11);
        send(0, DW'($urandom), 1, hs);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        chk("ready_before_stray", in_ready, 1);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_no_effect", {busy, in_ready}, 2'b11);
        for (int i = 1; i < FL; i++) send(0, DW'($urandom), 1, hs);
        wait_idle(0);

        // Engine timeout
        do_start(0, 7'b0001000);
        hang = 1'b1;
        send(0, DW'($urandom), 0, hs);
        while (cyc < hs + 65) @(negedge clk);
        chk("tmo_busy_before", {busy, err}, 2'b10);
        @(negedge clk);
        chk("tmo_after", {busy, err, done}, 3'b010);
        hang = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", err, 1);

        // Abort during WAIT_ENG of the second sample, then restart
        do_start(0, 7'b0000010);
        send(0, DW'($urandom), 1, hs);
        send(0, DW'($urandom), 0, hs);
        while (cyc < hs + 2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, in_ready, done}, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", {busy, done, out_valid}, 0);
        frame(7'($urandom));

        // Asynchronous reset mid-frame
        do_start(0, 7'h7F);
        send(0, DW'($urandom), 1, hs);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", {in_ready, out_valid, done, busy, err, eif.eng_clr, eif.eng_start}, 0);
        chk("arst_data", {out_data, out_addr, eif.eng_sec, eif.eng_x}, 0);
        sb.delete(); secq.delete(); done_due = -1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_stays_idle", {busy, in_ready}, 0);

        // Full 2048-sample frame, passthrough
        do_start(1, 7'h00);
        for (int i = 0; i < FLB; i++) send(1, DW'($urandom), 1, hs);
        wait_idle(1);
        chk("b_out_count", nb_out, FLB);

        chk("eng_clr_count", clr_cnt, clr_exp);
        chk("secq_drained", secq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
